// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the adder family: default geometry, stage count and ADD/SUB mode encoding.
package pipelined_cla_adder_pkg;

  localparam int unsigned DEFAULT_N     = 16;
  localparam int unsigned DEFAULT_BLOCK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } add_mode_e;

  // Number of lookahead slices; guarded so a zero BLOCK still elaborates far enough to report.
  function automatic int unsigned stage_count(input int unsigned n, input int unsigned block);
    return (block == 0) ? 1 : n / block;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_block.sv
// Combinational BLOCK-bit carry-lookahead group: sum, carry out, and carry into the top bit.
module cla_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    // Each carry is the flat sum-of-products of generate terms and cin, not a ripple chain.
    for (int unsigned i = 0; i < BLOCK; i++) begin
      term = cin;
      for (int unsigned m = 0; m <= i; m++) term = term & p[m];
      acc = term;
      for (int unsigned j = 0; j <= i; j++) begin
        term = g[j];
        for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    sum      = p ^ c[BLOCK-1:0];
    cout     = c[BLOCK];
    c_msb_in = c[BLOCK-1];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice per stage, valid/ready stream.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int unsigned S = stage_count(N, BLOCK);

  if ((BLOCK == 0) || ((N % ((BLOCK == 0) ? 1 : BLOCK)) != 0)) begin : g_bad_cfg
    $error("pipelined_cla_adder: N must be a non-zero multiple of BLOCK");
  end

  add_mode_e      mode;
  logic [N-1:0]   b_eff;
  logic           c0;
  logic           adv;

  // Bank k holds an operation whose slices below k are already summed; c_q[k] is its slice-k carry in.
  logic [S-1:0]   vld_q;
  logic [S-1:0]   c_q;
  logic [N-1:0]   a_q   [S];
  logic [N-1:0]   b_q   [S];
  logic [N-1:0]   sum_q [S];
  logic [N-1:0]   sum_next [S];

  logic [S-1:0][BLOCK-1:0] slice_sum;
  logic [S-1:0]            slice_cout;
  logic [S-1:0]            slice_cmsb;
  logic                    unused_bits;

  assign mode        = add_mode_e'(in_sub);
  assign b_eff       = (mode == MODE_SUB) ? ~in_b : in_b;
  assign c0          = (mode == MODE_SUB) | in_cin;
  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign unused_bits = ^{slice_cmsb, a_q[S-1], b_q[S-1]};

  for (genvar k = 0; k < S; k++) begin : g_stage
    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a        (a_q[k][k*BLOCK +: BLOCK]),
      .b        (b_q[k][k*BLOCK +: BLOCK]),
      .cin      (c_q[k]),
      .sum      (slice_sum[k]),
      .cout     (slice_cout[k]),
      .c_msb_in (slice_cmsb[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < S; k++) begin
      sum_next[k] = sum_q[k];
      sum_next[k][k*BLOCK +: BLOCK] = slice_sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      c_q       <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]   <= in_a;
        b_q[0]   <= b_eff;
        sum_q[0] <= '0;
        c_q[0]   <= c0;
      end
      for (int unsigned k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          a_q[k]   <= a_q[k-1];
          b_q[k]   <= b_q[k-1];
          sum_q[k] <= sum_next[k-1];
          c_q[k]   <= slice_cout[k-1];
        end
      end
      out_valid <= vld_q[S-1];
      if (vld_q[S-1]) begin
        out_sum  <= sum_next[S-1];
        out_cout <= slice_cout[S-1];
        out_ovf  <= slice_cout[S-1] ^ slice_cmsb[S-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed table, stall/stream, reset-flush and random scoreboard checks for pipelined_cla_adder.
module tb_pipelined_cla_adder;

  localparam int unsigned N = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] in_a, in_b, out_sum;

  logic        d8_valid, d8_ready_o, d8_out_valid, d8_out_ready, d8_cout, d8_ovf;
  logic [7:0]  d8_a, d8_b, d8_sum;
  logic        d32_valid, d32_ready_o, d32_out_valid, d32_out_ready, d32_cout, d32_ovf, d32_sub;
  logic [31:0] d32_a, d32_b, d32_sum;

  int checks = 0;
  int failures = 0;

  pipelined_cla_adder #(.N(N), .BLOCK(BLOCK)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_cla_adder #(.N(8), .BLOCK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d8_valid), .in_ready(d8_ready_o), .in_a(d8_a), .in_b(d8_b),
    .in_cin(1'b0), .in_sub(1'b0), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_sum(d8_sum), .out_cout(d8_cout), .out_ovf(d8_ovf)
  );

  pipelined_cla_adder #(.N(32), .BLOCK(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(d32_valid), .in_ready(d32_ready_o), .in_a(d32_a), .in_b(d32_b),
    .in_cin(1'b0), .in_sub(d32_sub), .out_valid(d32_out_valid), .out_ready(d32_out_ready),
    .out_sum(d32_sum), .out_cout(d32_cout), .out_ovf(d32_ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [15:0] bp;
    logic [16:0] r;
    logic        ovf;
    bp  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bp} + {16'd0, (sub | cin)};
    ovf = (a[15] == bp[15]) && (r[15] != a[15]);
    return {ovf, r[16], r[15:0]};
  endfunction

  task automatic run_stream(input int unsigned nops, input bit rnd);
    logic [17:0] q[$];
    logic [17:0] held;
    logic [3:0]  pat;
    int unsigned sent, got, cyc;
    bit          offered, stalled;
    pat = 4'b1001;
    sent = 0; got = 0; cyc = 0; offered = 0; stalled = 0; held = '0;
    while (got < nops && cyc < nops * 20 + 50) begin
      if (!offered && sent < nops && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (rnd) begin
          in_a = 16'($urandom); in_b = 16'($urandom);
          in_cin = 1'($urandom); in_sub = 1'($urandom);
        end else begin
          in_a = 16'((sent + 1) * 16'h1357); in_b = 16'h0F0F ^ 16'(sent << 4);
          in_cin = sent[1]; in_sub = sent[0];
        end
        offered = 1;
      end
      in_valid  = offered;
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : pat[cyc % 4];
      #1;
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_stable", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else chk("stream_data", {14'd0, out_ovf, out_cout, out_sum}, {14'd0, q.pop_front()});
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_ovf, out_cout, out_sum};
      if (in_valid && in_ready) begin
        q.push_back(golden(in_a, in_b, in_cin, in_sub));
        sent++;
        offered = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    chk("stream_count", got, nops);
    chk("stream_leftover", q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned seen;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n = 0; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
    d8_valid = 0; d8_a = '0; d8_b = '0; d8_out_ready = 1;
    d32_valid = 0; d32_a = '0; d32_b = '0; d32_sub = 0; d32_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_sum", {16'd0, out_sum}, 32'd0);
    chk("reset_flags", {30'd0, out_cout, out_ovf}, 32'd0);

    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_sub = vecs[i].sub;
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("vec_latency", n, S);
      chk("vec_sum", {16'd0, out_sum}, {16'd0, vecs[i].sum});
      chk("vec_cout", {31'd0, out_cout}, {31'd0, vecs[i].cout});
      chk("vec_ovf", {31'd0, out_ovf}, {31'd0, vecs[i].ovf});
    end
    @(posedge clk); #1;

    run_stream(8, 1'b0);

    // Three operations in flight, then a reset edge that also carries an offered handshake.
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'(16'h0100 + i); in_b = 16'h0011; in_cin = 0; in_sub = 0; in_valid = 1;
      @(posedge clk); #1;
    end
    rst_n = 0;
    @(posedge clk); #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_outputs", {14'd0, out_ovf, out_cout, out_sum}, 32'd0);
    rst_n = 1; in_valid = 0;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_results", seen, 32'd0);

    run_stream(10000, 1'b1);

    d8_a = 8'hFF; d8_b = 8'h01; d8_valid = 1;
    @(posedge clk); #1;
    d8_valid = 0;
    n = 0;
    while (!d8_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s1_latency", n, 32'd1);
    chk("s1_result", {22'd0, d8_ovf, d8_cout, d8_sum}, {22'd0, 1'b0, 1'b1, 8'h00});

    for (int i = 0; i < 2; i++) begin
      d32_a = (i == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      d32_b = 32'h0000_0001;
      d32_sub = (i == 1);
      d32_valid = 1;
      @(posedge clk); #1;
      d32_valid = 0;
      n = 0;
      while (!d32_out_valid && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk("w32_latency", n, 32'd8);
      chk("w32_sum", d32_sum, (i == 0) ? 32'h0000_0000 : 32'h7FFF_FFFF);
      chk("w32_flags", {30'd0, d32_cout, d32_ovf}, (i == 0) ? 32'd2 : 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
